// File: rtl/rmst_pkg.sv
// Shared types and helpers for the read-master tile controller.
package rmst_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        CONFIG = 3'd2,
        TRANS  = 3'd3,
        NEXT   = 3'd4
    } state_t;

    // Constant-only helper: exact log2 of a power-of-two bytes-per-word value.
    function automatic int unsigned log2_bpw(input int unsigned bpw);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) == bpw) r = i;
        end
        return r;
    endfunction

    function automatic logic [31:0] min_len(input logic [31:0] remain, input logic [31:0] tile);
        return (remain < tile) ? remain : tile;
    endfunction

endpackage

// File: rtl/rmst_addr_gen.sv
// Row/burst address walker: tracks the current burst address, words left in the row and the row index.
module rmst_addr_gen
    import rmst_pkg::*;
#(
    parameter int AW  = 32,
    parameter int LW  = 16,
    parameter int RW  = 12,
    parameter int IOW = 12,
    parameter int BPW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] cfg_base,
    input  logic [LW-1:0] cfg_row_len,
    input  logic [RW-1:0] cfg_rows,
    input  logic [AW-1:0] cfg_stride,
    input  logic          step,
    input  logic [IOW-1:0] step_len,
    output logic [AW-1:0] cur_addr,
    output logic [LW-1:0] remain,
    output logic          last_burst
);

    localparam int SH = int'(log2_bpw(BPW));

    logic [AW-1:0] row_base;
    logic [AW-1:0] stride;
    logic [LW-1:0] row_len;
    logic [RW-1:0] rows;
    logic [RW-1:0] row_idx;
    logic [LW-1:0] remain_nxt;
    logic [AW-1:0] addr_step;
    logic          row_end;

    assign remain_nxt = remain - LW'(step_len);
    assign row_end    = (remain_nxt == '0);
    assign last_burst = row_end && (row_idx == rows - RW'(1));
    assign addr_step  = AW'(step_len) << SH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_base <= '0;
            cur_addr <= '0;
            remain   <= '0;
            row_idx  <= '0;
            row_len  <= '0;
            rows     <= '0;
            stride   <= '0;
        end else if (load) begin
            row_base <= cfg_base;
            cur_addr <= cfg_base;
            remain   <= cfg_row_len;
            row_idx  <= '0;
            row_len  <= cfg_row_len;
            rows     <= cfg_rows;
            stride   <= cfg_stride;
        end else if (step) begin
            if (row_end) begin
                // Row exhausted: jump to the next row start rather than continuing linearly.
                row_idx  <= row_idx + RW'(1);
                row_base <= row_base + stride;
                cur_addr <= row_base + stride;
                remain   <= row_len;
            end else begin
                remain   <= remain_nxt;
                cur_addr <= cur_addr + addr_step;
            end
        end
    end

endmodule

// File: rtl/rmst_tile_ctrl.sv
// Splits a 2D load into bursts of at most TILE_LEN words and hands them to the Avalon read master.
module rmst_tile_ctrl
    import rmst_pkg::*;
#(
    parameter int AW       = 32,
    parameter int IOW      = 12,
    parameter int LW       = 16,
    parameter int RW       = 12,
    parameter int TILE_LEN = 128,
    parameter int BPW      = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_start,
    input  logic [AW-1:0]  cfg_base,
    input  logic [LW-1:0]  cfg_row_len,
    input  logic [RW-1:0]  cfg_rows,
    input  logic [AW-1:0]  cfg_stride,
    output logic           load_busy,
    output logic           load_done,
    output logic [AW-1:0]  param_raddr,
    output logic [IOW-1:0] param_iolen,
    output logic           load_trans_start,
    input  logic           load_trans_done,
    input  logic           load_fifo_almost_full,
    output logic [15:0]    burst_cnt
);

    state_t         state;
    logic           ag_load;
    logic           ag_step;
    logic [AW-1:0]  cur_addr;
    logic [LW-1:0]  remain;
    logic           last_burst;
    logic [IOW-1:0] burst_len;

    assign ag_load   = (state == IDLE) && load_start;
    assign ag_step   = (state == NEXT);
    assign load_busy = (state != IDLE);
    assign burst_len = IOW'(min_len(32'(remain), 32'(TILE_LEN)));

    rmst_addr_gen #(
        .AW (AW),
        .LW (LW),
        .RW (RW),
        .IOW(IOW),
        .BPW(BPW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (ag_load),
        .cfg_base   (cfg_base),
        .cfg_row_len(cfg_row_len),
        .cfg_rows   (cfg_rows),
        .cfg_stride (cfg_stride),
        .step       (ag_step),
        .step_len   (param_iolen),
        .cur_addr   (cur_addr),
        .remain     (remain),
        .last_burst (last_burst)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            load_done        <= 1'b0;
            param_raddr      <= '0;
            param_iolen      <= '0;
            load_trans_start <= 1'b0;
            burst_cnt        <= '0;
        end else begin
            load_done        <= 1'b0;
            load_trans_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        burst_cnt <= '0;
                        // Empty load completes immediately without touching the read master.
                        if (cfg_rows == '0 || cfg_row_len == '0) load_done <= 1'b1;
                        else                                     state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (!load_fifo_almost_full) state <= CONFIG;
                end
                CONFIG: begin
                    param_raddr      <= cur_addr;
                    param_iolen      <= burst_len;
                    load_trans_start <= 1'b1;
                    if (burst_cnt != 16'hFFFF) burst_cnt <= burst_cnt + 16'd1;
                    state            <= TRANS;
                end
                TRANS: begin
                    if (load_trans_done) state <= NEXT;
                end
                NEXT: begin
                    if (last_burst) begin
                        state     <= IDLE;
                        load_done <= 1'b1;
                    end else begin
                        state     <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmst_tile_ctrl.sv
// Bench for rmst_tile_ctrl: table-driven loads checked burst-by-burst against a scoreboard queue.
module tb_rmst_tile_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [31:0] cfg_base;
    logic [15:0] cfg_row_len;
    logic [11:0] cfg_rows;
    logic [31:0] cfg_stride;
    logic        load_busy;
    logic        load_done;
    logic [31:0] param_raddr;
    logic [11:0] param_iolen;
    logic        load_trans_start;
    logic        load_trans_done;
    logic        load_fifo_almost_full;
    logic [15:0] burst_cnt;

    rmst_tile_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .load_start           (load_start),
        .cfg_base             (cfg_base),
        .cfg_row_len          (cfg_row_len),
        .cfg_rows             (cfg_rows),
        .cfg_stride           (cfg_stride),
        .load_busy            (load_busy),
        .load_done            (load_done),
        .param_raddr          (param_raddr),
        .param_iolen          (param_iolen),
        .load_trans_start     (load_trans_start),
        .load_trans_done      (load_trans_done),
        .load_fifo_almost_full(load_fifo_almost_full),
        .burst_cnt            (burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    typedef struct {
        logic [31:0] base;
        int          rows;
        int          len;
        logic [31:0] stride;
        int          dly;
        int          exp_bursts;
        int          exp_cnt;
    } vec_t;

    burst_t exp_q[$];
    vec_t   vt[6];
    int     checks = 0;
    int     failures = 0;
    int     n_starts = 0;
    int     n_dones = 0;
    int     done_dly = 1;
    bit     rm_pend = 1'b0;
    int     rm_wait = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every burst start is popped and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (load_done) n_dones++;
            if (load_trans_start) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_burst actual addr=0x%0h len=%0d required none", param_raddr, param_iolen);
                end else begin
                    burst_t b;
                    b = exp_q.pop_front();
                    check("burst_addr", 64'(param_raddr), 64'(b.addr));
                    check("burst_len", 64'(param_iolen), 64'(b.len));
                    check("busy_in_trans", 64'(load_busy), 64'd1);
                end
            end
        end
    end

    // Read-master model: answers each burst start after done_dly cycles (0 = same cycle).
    initial begin
        load_trans_done = 1'b0;
        forever begin
            @(negedge clk);
            load_trans_done = 1'b0;
            if (rst) begin
                rm_pend = 1'b0;
            end else begin
                if (load_trans_start) begin
                    rm_pend = 1'b1;
                    rm_wait = done_dly;
                end
                if (rm_pend) begin
                    if (rm_wait == 0) begin
                        load_trans_done = 1'b1;
                        rm_pend = 1'b0;
                    end else begin
                        rm_wait--;
                    end
                end
            end
        end
    end

    task automatic push_model(input logic [31:0] base, input int rows, input int len,
                              input logic [31:0] stride, output logic [31:0] last_addr);
        last_addr = 32'h0;
        for (int r = 0; r < rows; r++) begin
            logic [31:0] a;
            int rem;
            a   = base + 32'(r) * stride;
            rem = len;
            while (rem > 0) begin
                burst_t b;
                int l;
                l = (rem < 128) ? rem : 128;
                b.addr = a;
                b.len  = l;
                exp_q.push_back(b);
                last_addr = a;
                a   = a + 32'(l * 4);
                rem = rem - l;
            end
        end
    endtask

    // Called right after a negedge; returns at the next negedge with load_start low.
    task automatic start_load(input logic [31:0] base, input int rows, input int len, input logic [31:0] stride);
        load_start  = 1'b1;
        cfg_base    = base;
        cfg_rows    = 12'(rows);
        cfg_row_len = 16'(len);
        cfg_stride  = stride;
        @(negedge clk);
        load_start  = 1'b0;
        cfg_base    = $urandom;
        cfg_rows    = 12'($urandom);
        cfg_row_len = 16'($urandom);
        cfg_stride  = $urandom;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (load_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) $display("FAIL wait_done actual=timeout required=load_done");
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s0;
        int d0;
        bit ok;
        logic [31:0] last_a;
        done_dly = v.dly;
        s0 = n_starts;
        push_model(v.base, v.rows, v.len, v.stride, last_a);
        start_load(v.base, v.rows, v.len, v.stride);
        wait_done(ok);
        d0 = n_dones;
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
        check({tag, "_bursts"}, 64'(n_starts - s0), 64'(v.exp_bursts));
        check({tag, "_burst_cnt"}, 64'(burst_cnt), 64'(v.exp_cnt));
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_raddr_hold"}, 64'(param_raddr), 64'(last_a));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(load_done), 64'd0);
        check({tag, "_idle_after"}, 64'(load_busy), 64'd0);
        check({tag, "_single_done"}, 64'(n_dones - d0), 64'd0);
    endtask

    initial begin
        bit ok;
        int s0;
        int d0;
        logic [31:0] la;

        vt[0] = '{32'h0000_1000, 1, 300, 32'h0,        2, 3, 3};
        vt[1] = '{32'h0000_0000, 3, 64,  32'h400,      1, 3, 3};
        vt[2] = '{32'h0000_2000, 2, 130, 32'h1000,     0, 4, 4};
        vt[3] = '{32'hFFFF_FFF0, 1, 10,  32'h0,        1, 1, 1};
        vt[4] = '{32'hFFFF_FF00, 2, 256, 32'h200,      3, 4, 4};
        vt[5] = '{32'h0000_0040, 1, 128, 32'h0,        0, 1, 1};

        rst = 1'b1;
        load_start = 1'b0;
        cfg_base = '0;
        cfg_row_len = '0;
        cfg_rows = '0;
        cfg_stride = '0;
        load_fifo_almost_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(load_busy), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_raddr", 64'(param_raddr), 64'd0);
        check("rst_iolen", 64'(param_iolen), 64'd0);
        check("rst_tstart", 64'(load_trans_start), 64'd0);
        check("rst_bcnt", 64'(burst_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

        // Empty loads: done one cycle after start, never busy, no burst.
        for (int k = 0; k < 2; k++) begin
            s0 = n_starts;
            if (k == 0) start_load(32'h3000, 2, 0, 32'h100);
            else        start_load(32'h3000, 0, 16, 32'h100);
            check("empty_done", 64'(load_done), 64'd1);
            check("empty_busy", 64'(load_busy), 64'd0);
            check("empty_bcnt", 64'(burst_cnt), 64'd0);
            @(negedge clk);
            check("empty_done_pulse", 64'(load_done), 64'd0);
            check("empty_no_burst", 64'(n_starts - s0), 64'd0);
        end

        // Backpressure: start held off until two cycles after almost_full drops.
        done_dly = 1;
        s0 = n_starts;
        push_model(32'h5000, 1, 16, 32'h0, la);
        load_fifo_almost_full = 1'b1;
        start_load(32'h5000, 1, 16, 32'h0);
        repeat (19) @(negedge clk);
        check("af_no_start", 64'(n_starts - s0), 64'd0);
        check("af_busy", 64'(load_busy), 64'd1);
        load_fifo_almost_full = 1'b0;
        @(negedge clk);
        check("af_start_t1", 64'(load_trans_start), 64'd0);
        @(negedge clk);
        check("af_start_t2", 64'(load_trans_start), 64'd1);
        wait_done(ok);
        check("af_done", 64'(ok), 64'd1);
        @(negedge clk);

        // load_start while busy must be ignored.
        s0 = n_starts;
        push_model(32'h6000, 1, 200, 32'h0, la);
        start_load(32'h6000, 1, 200, 32'h0);
        repeat (3) @(negedge clk);
        start_load(32'h9000, 5, 500, 32'h1000);
        wait_done(ok);
        check("busy_ign_done", 64'(ok), 64'd1);
        check("busy_ign_bursts", 64'(n_starts - s0), 64'd2);
        check("busy_ign_bcnt", 64'(burst_cnt), 64'd2);
        @(negedge clk);

        // Back-to-back: a new start in the load_done cycle is accepted.
        s0 = n_starts;
        push_model(32'h7000, 1, 10, 32'h0, la);
        push_model(32'h8000, 2, 20, 32'h100, la);
        start_load(32'h7000, 1, 10, 32'h0);
        wait_done(ok);
        start_load(32'h8000, 2, 20, 32'h100);
        check("b2b_busy", 64'(load_busy), 64'd1);
        wait_done(ok);
        check("b2b_done", 64'(ok), 64'd1);
        check("b2b_bursts", 64'(n_starts - s0), 64'd3);
        check("b2b_bcnt", 64'(burst_cnt), 64'd2);
        check("b2b_queue", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a burst aborts silently.
        done_dly = 10;
        s0 = n_starts;
        push_model(vt[0].base, 1, 300, 32'h0, la);
        start_load(vt[0].base, 1, 300, 32'h0);
        for (int i = 0; i < 100 && n_starts == s0; i++) @(negedge clk);
        check("rst_mid_started", 64'(n_starts - s0), 64'd1);
        repeat (2) @(negedge clk);
        d0 = n_dones;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(load_busy), 64'd0);
        check("rst_mid_raddr", 64'(param_raddr), 64'd0);
        check("rst_mid_iolen", 64'(param_iolen), 64'd0);
        check("rst_mid_bcnt", 64'(burst_cnt), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_no_done", 64'(n_dones - d0), 64'd0);
        run_vec(vt[0], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=hang required=finish");
        $fatal(1);
    end

endmodule
